// File: rtl/iecdrv_rom_arbiter.sv
// iecdrv_rom_arbiter: time-division arbiter sharing a standard and an alternate
// ROM image between up to eight emulated IEC drive cores.
// Ports: clk, reset (sync, active-high), ph2_f (sweep start strobe),
//   drv_addr/drv_en/rom_sel (per-drive request, packed by slot),
//   mem_addr/mem_en (registered shared ROM port), mem_q_a/mem_q_b (ROM data),
//   drv_data/drv_valid (per-drive captured byte and update pulse),
//   busy (sweep in progress), overrun (sticky), ovr_clr (clears overrun).
module iecdrv_rom_arbiter #(
   parameter int DRIVES = 4,
   parameter int AW     = 15,
   parameter int DW     = 8,
   parameter int RDLAT  = 2,
   localparam int NDR   = (DRIVES < 1) ? 1 : (DRIVES > 8) ? 8 : DRIVES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ph2_f,
   input  logic [NDR*AW-1:0] drv_addr,
   input  logic [NDR-1:0]    drv_en,
   input  logic [NDR-1:0]    rom_sel,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_en,
   input  logic [DW-1:0]     mem_q_a,
   input  logic [DW-1:0]     mem_q_b,
   output logic [NDR*DW-1:0] drv_data,
   output logic [NDR-1:0]    drv_valid,
   output logic              busy,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int LAT = (RDLAT < 1) ? 1 : (RDLAT > 4) ? 4 : RDLAT;
   localparam int SCW = 4;
   localparam logic [SCW-1:0] SC_NDR  = SCW'(NDR);
   localparam logic [SCW-1:0] SC_LAST = SCW'(NDR + LAT - 1);

   logic [SCW-1:0] sc;
   // Tag pipeline: a set tag_v means "capture this slot when it emerges";
   // disabled slots enter with tag_v clear so they only burn their time slot.
   logic [LAT-1:0] tag_v;
   logic [LAT-1:0] tag_sel;
   logic [2:0]     tag_k [LAT];

   logic           issue;
   logic [AW-1:0]  iss_addr;
   logic           iss_en;
   logic           iss_sel;

   // A ph2_f edge never issues; it only (re)starts the sweep.
   assign issue = busy & ~ph2_f & (sc < SC_NDR);

   always_comb begin
      iss_addr = '0;
      iss_en   = 1'b0;
      iss_sel  = 1'b0;
      for (int k = 0; k < NDR; k++) begin
         if (sc == SCW'(k)) begin
            iss_addr = drv_addr[k*AW +: AW];
            iss_en   = drv_en[k];
            iss_sel  = rom_sel[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sc        <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         mem_addr  <= '0;
         mem_en    <= 1'b0;
         drv_data  <= '0;
         drv_valid <= '0;
         tag_v     <= '0;
         tag_sel   <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_k[i] <= '0;
         end
      end else begin
         drv_valid <= '0;
         // The capture at the head of the pipe still lands on a restart edge.
         if (tag_v[LAT-1]) begin
            for (int k = 0; k < NDR; k++) begin
               if (tag_k[LAT-1] == 3'(k)) begin
                  drv_data[k*DW +: DW] <= tag_sel[LAT-1] ? mem_q_b : mem_q_a;
                  drv_valid[k]         <= 1'b1;
               end
            end
         end
         for (int i = LAT - 1; i > 0; i--) begin
            tag_v[i]   <= tag_v[i-1];
            tag_sel[i] <= tag_sel[i-1];
            tag_k[i]   <= tag_k[i-1];
         end
         tag_v[0]   <= issue & iss_en;
         tag_sel[0] <= iss_sel;
         tag_k[0]   <= sc[2:0];

         if (ph2_f && busy) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end

         if (ph2_f) begin
            // Start or restart: drop every capture still in flight.
            tag_v  <= '0;
            busy   <= 1'b1;
            sc     <= '0;
            mem_en <= 1'b0;
         end else begin
            mem_en <= issue & iss_en;
            if (issue) begin
               mem_addr <= iss_addr;
            end
            if (busy) begin
               if (sc == SC_LAST) begin
                  busy <= 1'b0;
               end else begin
                  sc <= sc + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_iecdrv_rom_arbiter.sv
// tb_iecdrv_rom_arbiter: directed bench for iecdrv_rom_arbiter in four
// configurations, checked every cycle against an event-schedule model.
module tb_iecdrv_rom_arbiter;

   localparam int NI = 4;
   localparam int NS [NI] = '{4, 8, 1, 8};
   localparam int RL [NI] = '{2, 1, 4, 1};

   logic clk;
   logic reset;
   logic ph2_f;
   logic ovr_clr;
   logic [14:0] addr [8];
   logic [7:0]  en;
   logic [7:0]  sel;
   logic [119:0] addr_p;

   logic [14:0] ma [NI];
   logic        me [NI];
   logic [7:0]  qa [NI];
   logic [7:0]  qb [NI];
   logic        bz [NI];
   logic        ov [NI];
   logic [31:0] dd0;
   logic [63:0] dd1;
   logic [7:0]  dd2;
   logic [63:0] dd3;
   logic [3:0]  dv0;
   logic [7:0]  dv1;
   logic [0:0]  dv2;
   logic [7:0]  dv3;
   logic [63:0] a_data [NI];
   logic [7:0]  a_valid [NI];

   logic [14:0] rp [NI][3];

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   bit started = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int k = 0; k < 8; k++) addr_p[k*15 +: 15] = addr[k];
   end

   iecdrv_rom_arbiter #(.DRIVES(4), .RDLAT(2)) u0 (
      .clk(clk), .reset(reset), .ph2_f(ph2_f),
      .drv_addr(addr_p[59:0]), .drv_en(en[3:0]), .rom_sel(sel[3:0]),
      .mem_addr(ma[0]), .mem_en(me[0]), .mem_q_a(qa[0]), .mem_q_b(qb[0]),
      .drv_data(dd0), .drv_valid(dv0), .busy(bz[0]), .overrun(ov[0]),
      .ovr_clr(ovr_clr));

   iecdrv_rom_arbiter #(.DRIVES(8), .RDLAT(1)) u1 (
      .clk(clk), .reset(reset), .ph2_f(ph2_f),
      .drv_addr(addr_p), .drv_en(en), .rom_sel(sel),
      .mem_addr(ma[1]), .mem_en(me[1]), .mem_q_a(qa[1]), .mem_q_b(qb[1]),
      .drv_data(dd1), .drv_valid(dv1), .busy(bz[1]), .overrun(ov[1]),
      .ovr_clr(ovr_clr));

   iecdrv_rom_arbiter #(.DRIVES(1), .RDLAT(4)) u2 (
      .clk(clk), .reset(reset), .ph2_f(ph2_f),
      .drv_addr(addr_p[14:0]), .drv_en(en[0:0]), .rom_sel(sel[0:0]),
      .mem_addr(ma[2]), .mem_en(me[2]), .mem_q_a(qa[2]), .mem_q_b(qb[2]),
      .drv_data(dd2), .drv_valid(dv2), .busy(bz[2]), .overrun(ov[2]),
      .ovr_clr(ovr_clr));

   iecdrv_rom_arbiter #(.DRIVES(12), .RDLAT(1)) u3 (
      .clk(clk), .reset(reset), .ph2_f(ph2_f),
      .drv_addr(addr_p), .drv_en(en), .rom_sel(sel),
      .mem_addr(ma[3]), .mem_en(me[3]), .mem_q_a(qa[3]), .mem_q_b(qb[3]),
      .drv_data(dd3), .drv_valid(dv3), .busy(bz[3]), .overrun(ov[3]),
      .ovr_clr(ovr_clr));

   assign a_data[0]  = {32'h0, dd0};
   assign a_data[1]  = dd1;
   assign a_data[2]  = {56'h0, dd2};
   assign a_data[3]  = dd3;
   assign a_valid[0] = {4'h0, dv0};
   assign a_valid[1] = dv1;
   assign a_valid[2] = {7'h0, dv2};
   assign a_valid[3] = dv3;

   // ROM stub: RL-1 address registers; bank A = low address byte, B = its inverse.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         rp[i][0] <= ma[i];
         rp[i][1] <= rp[i][0];
         rp[i][2] <= rp[i][1];
      end
   end

   always_comb begin
      for (int i = 0; i < NI; i++) begin
         qa[i] = (RL[i] == 1) ? ma[i][7:0] : rp[i][RL[i]-2][7:0];
         qb[i] = ~qa[i];
      end
   end

   // Model: each accepted ph2_f at edge s schedules slot k to issue at s+1+k
   // and land at s+1+k+RL; busy spans edges s..s+N+RL.
   int          cyc = 0;
   bit          m_busy [NI];
   int          m_s    [NI];
   bit          m_ovr  [NI];
   logic [14:0] m_ma   [NI];
   bit          m_me   [NI];
   logic [7:0]  m_val  [NI];
   logic [7:0]  m_dat  [NI][8];
   bit          pend   [NI][8];
   int          capc   [NI][8];
   bit          pen    [NI][8];
   logic [7:0]  pval   [NI][8];

   task automatic model_step(input int i);
      int  n = NS[i];
      bit  b0 = m_busy[i];
      int  j;
      if (reset) begin
         m_busy[i] = 0; m_ovr[i] = 0; m_ma[i] = '0; m_me[i] = 0; m_val[i] = '0;
         for (int k = 0; k < 8; k++) begin
            m_dat[i][k] = '0;
            pend[i][k] = 0;
         end
         return;
      end
      m_val[i] = '0;
      for (int k = 0; k < n; k++) begin
         if (pend[i][k] && capc[i][k] == cyc) begin
            pend[i][k] = 0;
            if (pen[i][k]) begin
               m_dat[i][k] = pval[i][k];
               m_val[i][k] = 1'b1;
            end
         end
      end
      if (ph2_f && b0) m_ovr[i] = 1;
      else if (ovr_clr) m_ovr[i] = 0;
      if (ph2_f) begin
         for (int k = 0; k < 8; k++) pend[i][k] = 0;
         m_busy[i] = 1;
         m_s[i] = cyc;
         m_me[i] = 0;
      end else if (b0) begin
         j = cyc - m_s[i] - 1;
         if (j >= 0 && j < n) begin
            m_ma[i] = addr[j];
            m_me[i] = en[j];
            pend[i][j] = 1;
            capc[i][j] = cyc + RL[i];
            pen[i][j] = en[j];
            pval[i][j] = sel[j] ? ~addr[j][7:0] : addr[j][7:0];
         end else begin
            m_me[i] = 0;
         end
         if (cyc == m_s[i] + n + RL[i]) m_busy[i] = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_busy[i] = 0; m_s[i] = 0; m_ovr[i] = 0; m_ma[i] = '0; m_me[i] = 0;
         m_val[i] = '0;
         for (int k = 0; k < 8; k++) begin
            m_dat[i][k] = '0; pend[i][k] = 0; capc[i][k] = 0;
            pen[i][k] = 0; pval[i][k] = '0;
         end
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < NI; i++) model_step(i);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      logic [63:0] ed;
      logic [7:0]  ev;
      forever begin
         @(negedge clk);
         if (started) begin
            for (int i = 0; i < NI; i++) begin
               ed = '0;
               ev = '0;
               for (int k = 0; k < NS[i]; k++) begin
                  ed[k*8 +: 8] = m_dat[i][k];
                  ev[k] = m_val[i][k];
               end
               chk($sformatf("u%0d data @%0d", i, cyc), a_data[i], ed);
               chk($sformatf("u%0d valid @%0d", i, cyc), 64'(a_valid[i]), 64'(ev));
               chk($sformatf("u%0d busy @%0d", i, cyc), 64'(bz[i]), 64'(m_busy[i]));
               chk($sformatf("u%0d overrun @%0d", i, cyc), 64'(ov[i]), 64'(m_ovr[i]));
               chk($sformatf("u%0d mem_addr @%0d", i, cyc), 64'(ma[i]), 64'(m_ma[i]));
               chk($sformatf("u%0d mem_en @%0d", i, cyc), 64'(me[i]), 64'(m_me[i]));
            end
         end
      end
   end

   task automatic set_addr(input int b);
      for (int k = 0; k < 8; k++) addr[k] = 15'(((k + 1) & 7) << 12) | 15'(b + k);
   endtask

   task automatic start();
      ph2_f = 1;
      @(negedge clk);
      ph2_f = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int bc;
   int c0;
   int c1;

   initial begin
      reset = 1; ph2_f = 0; ovr_clr = 0; en = 8'hFF; sel = 8'h00;
      set_addr(0);
      @(negedge clk);
      started = 1;
      idle(2);
      chk("rst busy", 64'(bz[0]), 64'd0);
      chk("rst data", a_data[1], 64'd0);
      reset = 0;
      idle(2);

      // Basic sweep, all banks A.
      start();
      bc = bz[0] ? 1 : 0;
      for (int m = 1; m <= 10; m++) begin
         @(negedge clk);
         if (bz[0]) bc++;
         if (m >= 3 && m <= 6) chk($sformatf("t1 u0 valid P%0d", m), 64'(a_valid[0]), 64'(1 << (m - 3)));
         if (m >= 2 && m <= 9) chk($sformatf("t1 u1 valid P%0d", m), 64'(a_valid[1]), 64'(1 << (m - 2)));
         if (m == 5) chk("t1 u2 valid", 64'(a_valid[2]), 64'd1);
      end
      chk("t1 u0 busy cycles", 64'(bc), 64'd6);
      chk("t1 u0 data", a_data[0], 64'h03020100);
      chk("t1 u1 data", a_data[1], 64'h0706050403020100);
      chk("t1 u3 data", a_data[3], 64'h0706050403020100);

      // Bank select.
      sel = 8'b0000_0101;
      start();
      idle(12);
      chk("t2 u0 data", a_data[0], 64'h03FD01FF);

      // Disabled slot keeps its byte.
      sel = 8'h00;
      addr[2] = 15'h3055;
      start();
      idle(12);
      chk("t3 u0 pre", a_data[0], 64'h03550100);
      addr[0] = 15'h1010; addr[1] = 15'h2011; addr[2] = 15'h3002; addr[3] = 15'h4013;
      en = 8'hFB;
      start();
      idle(2);
      chk("t3 mem_en slot1", 64'(me[0]), 64'd1);
      idle(1);
      chk("t3 mem_en slot2", 64'(me[0]), 64'd0);
      idle(2);
      chk("t3 valid slot2", 64'(a_valid[0]), 64'd0);
      idle(8);
      chk("t3 u0 data", a_data[0], 64'h13551110);
      en = 8'hFF;
      set_addr(0);
      idle(2);

      // Overrun: second ph2_f at E0+3 with new addresses.
      start();
      idle(2);
      ph2_f = 1;
      set_addr(8'h20);
      @(negedge clk);
      ph2_f = 0;
      chk("t4 overrun", 64'(ov[0]), 64'd1);
      c0 = 0; c1 = 0;
      for (int m = 3; m <= 12; m++) begin
         if (m > 3) @(negedge clk);
         if (a_valid[0][0]) c0++;
         if (a_valid[0][1]) c1++;
         if (m == 8) chk("t4 busy P8", 64'(bz[0]), 64'd1);
         if (m == 9) chk("t4 busy P9", 64'(bz[0]), 64'd0);
      end
      chk("t4 slot0 pulses", 64'(c0), 64'd2);
      chk("t4 slot1 pulses", 64'(c1), 64'd1);
      chk("t4 u0 data", a_data[0], 64'h23222120);
      idle(2);
      ovr_clr = 1;
      @(negedge clk);
      ovr_clr = 0;
      chk("t4 ovr_clr", 64'(ov[0]), 64'd0);
      start();
      idle(2);
      ph2_f = 1;
      ovr_clr = 1;
      @(negedge clk);
      ph2_f = 0;
      ovr_clr = 0;
      chk("t4 set beats clr", 64'(ov[0]), 64'd1);
      idle(12);
      ovr_clr = 1;
      @(negedge clk);
      ovr_clr = 0;
      idle(1);

      // Reset mid-sweep, with a coincident ph2_f.
      start();
      idle(3);
      reset = 1;
      ph2_f = 1;
      @(negedge clk);
      reset = 0;
      ph2_f = 0;
      chk("t5 data", a_data[0], 64'd0);
      chk("t5 busy", 64'(bz[0]), 64'd0);
      c0 = 0;
      for (int m = 0; m < 10; m++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) if (a_valid[i] != 0 || bz[i]) c0++;
      end
      chk("t5 quiet after reset", 64'(c0), 64'd0);

      // Recovery sweep.
      set_addr(0);
      sel = 8'hAA;
      start();
      idle(12);
      chk("t6 u0 data", a_data[0], 64'hFC02FE00);
      chk("t6 u2 data", a_data[2], 64'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/iecdrv_rom_arbiter.md
# iecdrv_rom_arbiter

Time-division arbiter that lets up to eight emulated IEC drive cores share one or two synchronous ROM images (standard and alternate). It sits between the per-drive CPU address buses and the ROM memories inside a multi-drive wrapper. Once per drive CPU phase, on the `ph2_f` strobe, it sweeps all drive slots, issues each drive's address, and captures the returned byte into a per-drive holding register. It generalises the fixed 4-slot scheme to a parametrised drive count, address/data width and memory latency, and adds per-drive bank select, slot enables, valid strobes and overrun detection.

## Interface
Parameters:
- `DRIVES`, default 4: number of drive slots; clamped internally to 1..8 (`NDR`).
- `AW`, default 15: ROM address width.
- `DW`, default 8: ROM data width.
- `RDLAT`, default 2: clock edges from a `mem_addr` update to the edge that samples `mem_q_*`; legal range 1..4. The value 2 corresponds to a BRAM with a registered address input.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ph2_f` in 1: sweep start strobe, one cycle wide.
- `drv_addr` in NDR*AW: packed per-drive addresses; slot k occupies bits [k*AW +: AW].
- `drv_en` in NDR: slot enables.
- `rom_sel` in NDR: per-drive bank select; 1 selects `mem_q_b`.
- `mem_addr` out AW: registered shared ROM address.
- `mem_en` out 1: registered read enable.
- `mem_q_a` in DW: standard ROM data.
- `mem_q_b` in DW: alternate ROM data.
- `drv_data` out NDR*DW: packed captured bytes; slot k occupies bits [k*DW +: DW].
- `drv_valid` out NDR: one-cycle pulse per drive when its `drv_data` slice updates.
- `busy` out 1: a sweep is in progress.
- `overrun` out 1: sticky flag, set when `ph2_f` arrives while `busy`.
- `ovr_clr` in 1: clears `overrun`.

## Operation
- Sweep is driven by a slot counter `sc` (0..NDR+RDLAT) and a `busy` flag. Idle means `busy=0`.
- Issue phase:
  - At slot k (0..NDR-1), the block registers `mem_addr <= drv_addr[k]` and `mem_en <= drv_en[k]`.
  - `rom_sel[k]` and `drv_en[k]` enter a RDLAT-deep tag pipeline together with k.
  - After the last slot, `mem_en <= 0` and `mem_addr` holds its last value.
- Capture phase:
  - When the tag pipeline emits slot k with its enable set, `drv_data[k] <= rom_sel_tag ? mem_q_b : mem_q_a` and `drv_valid[k]` pulses.
  - Disabled slots still consume their time slot. Their `drv_data` slice holds and no valid pulse is produced.
- `busy` clears on the edge that performs the last capture.
- `ph2_f` while busy:
  - Sets `overrun`.
  - Restarts the sweep at slot 0 and flushes the tag pipeline.
  - Slots not yet captured in the aborted sweep keep their old data and receive no valid pulse.
- `ovr_clr` clears `overrun`. If `ovr_clr` and a set condition occur in the same cycle, set wins.
- Reset values: `mem_addr` = 0, `mem_en` = 0, `drv_data` = all 0, `drv_valid` = 0, `busy` = 0, `overrun` = 0, tag pipeline empty.
- Reset has priority over everything. A `ph2_f` in the same cycle as reset is ignored. Reset mid-sweep aborts the sweep with no further captures.
- `ph2_f` inputs are ignored on the first edge after reset deasserts only if reset is still high on that edge; otherwise they are accepted normally.

## Timing
- Let E0 be the edge that samples `ph2_f=1`. At E0, `busy` becomes 1 and `sc` becomes 0.
- `mem_addr` takes `drv_addr[k]` at edge E0+1+k, sampling the value present in the preceding cycle.
- `drv_data[k]` updates at edge E0+1+k+RDLAT. `drv_valid[k]` is high for the cycle following that edge.
- The last capture and the `busy` clear both occur at E0+NDR+RDLAT.
- Example, NDR=4 and RDLAT=2: captures occur at E0+3, E0+4, E0+5 and E0+6.
- The `ph2_f` period must exceed NDR+RDLAT cycles; otherwise `overrun` sets.
- Width rules:
  - `sc` is wide enough for NDR+RDLAT (4 bits suffice).
  - No arithmetic on addresses or data; paths are pure mux and register.
- `drv_addr` must be stable from E0 through E0+NDR. The block samples it once per slot only.

## Test plan
- NDR=4, RDLAT=2, `mem_q_a` model = low byte of address, `drv_addr` = 0x1000/0x2001/0x3002/0x4003, one `ph2_f` -> `drv_data` = 00/01/02/03; `drv_valid` bits 0..3 pulse after E0+3..E0+6 respectively; `busy` high for 6 cycles.
- `rom_sel` = 4'b0101, `mem_q_b` = `mem_q_a` XOR 0xFF, same addresses -> `drv_data` = FF/01/FD/03.
- `drv_en` = 4'b1011, previous `drv_data[2]` = 0x55 -> slot 2 keeps 0x55, no `drv_valid[2]`; `mem_en` low during slot 2's issue cycle; all other slots update.
- Second `ph2_f` at E0+3 -> `overrun` = 1; slot 0 captured once from the first sweep; new sweep completes at E0+3+6; a later `ovr_clr` clears `overrun`; `ovr_clr` coincident with another overrun leaves `overrun` = 1.
- Reset asserted at E0+4 -> all outputs at their reset values on the next edge; no `drv_valid` pulses afterwards; a `ph2_f` coincident with reset starts no sweep.
- DRIVES=8, RDLAT=1; and DRIVES=1, RDLAT=4 -> captures at E0+2..E0+9 and at E0+5 respectively, data correct; DRIVES=12 behaves as NDR=8.
